lfa_accum_stage: RTL and testbench
==================================

Name: lfa_accum_stage

Overview:
- Sequential stage directly downstream of the 27-bit Ladner-Fischer adder UBLFA_26_0_26_0.
- Accepts a valid/ready stream of 27-bit operands and accumulates each packet, delimited by IN_LAST, into a wide sum.
- One internal UBLFA_26_0_26_0 instance adds the low 27 accumulator bits to the incoming operand. Its carry-out S[27] increments a CW-bit upper counter.
- The packet sum, beat count and overflow flag are presented on a valid/ready output port.

Parameters:
- CW, 6, width of upper carry counter; OUT_SUM width is 27+CW.
- CNT_W, 16, width of beat counter OUT_COUNT.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  synchronous active-low reset, sampled on CLK rising edge.
- IN_VALID  input  1  operand beat valid.
- IN_READY  output  1  stage can accept a beat.
- IN_DATA  input  27  unsigned operand.
- IN_LAST  input  1  beat is final beat of packet.
- OUT_VALID  output  1  packet result valid.
- OUT_READY  input  1  consumer accepts result.
- OUT_SUM  output  27+CW  packet sum modulo 2^(27+CW).
- OUT_COUNT  output  CNT_W  beats in packet, saturating.
- OUT_OVF  output  1  upper counter wrapped during packet.

Behaviour:
- Two internal stages:
  - S1: operand register holding data, last and valid bit s1_v.
  - S2: accumulator acc_lo[26:0], acc_hi[CW-1:0], count, ovf.
  - FSM with states ACCUM and DONE.
- Reset (RST_N=0 at edge), regardless of state or in-flight beat:
  - s1_v=0, acc=0, count=0, ovf=0, state=ACCUM.
  - Outputs: OUT_VALID=0, OUT_SUM=0, OUT_COUNT=0, OUT_OVF=0, IN_READY=0 during the reset cycle.
  - An in-flight packet is discarded.
- IN_READY = RST_N & (!s1_v | drain). drain = s1_v & (state==ACCUM). IN_READY is combinational from registered state only, never from IN_VALID.
- Input handshake: IN_VALID&IN_READY at an edge loads S1 and sets s1_v=1. If drain occurs without a load, s1_v=0. Full throughput of 1 beat/cycle in ACCUM.
- Drain edge (drain=1):
  - Adder X=acc_lo, Y=s1_data, internal carry-in 0.
  - acc_lo <= S[26:0].
  - If S[27]=1: acc_hi <= acc_hi+1. If acc_hi was all-ones it wraps to 0 and ovf <= 1 (sticky for the packet).
  - count <= count+1, saturating at 2^CNT_W-1.
  - If s1_last=1: state <= DONE.
- DONE:
  - OUT_VALID=1; OUT_SUM={acc_hi,acc_lo}, OUT_COUNT=count, OUT_OVF=ov.
  - Outputs are stable until accepted.
  - S1 may still load one beat (s1_v=0 on entry), then IN_READY=0.
- Output accept edge (DONE & OUT_READY):
  - acc, count and ovf clear to 0; state <= ACCUM.
  - No drain on this edge. A held S1 beat drains on the following edge as the first beat of the next packet.
- Latency: input handshake at edge t, drain at edge t+1, OUT_VALID high after edge t+1 for a last beat with no backpressure.
- OUT_READY while OUT_VALID=0 is ignored.
- IN_LAST on the first beat yields a single-beat packet, count=1.
- A zero-valued operand still counts as a beat.
- There are no empty packets; a result is produced only on IN_LAST.

Test Plan:
- Reset, then beats 0x7FFFFFF, 0x7FFFFFF, 0x0000001(last) on consecutive cycles with OUT_READY=1. Required: OUT_SUM=0x00FFFFFFF, OUT_COUNT=3, OUT_OVF=0; OUT_VALID high 2 cycles after the last handshake for exactly 1 cycle.
- Single beat 5 with IN_LAST. Required: OUT_SUM=5, OUT_COUNT=1, OUT_OVF=0.
- 64 beats of 0x7FFFFFF (CW=6). Required: OUT_SUM=0x1FFFFFFC0, OUT_OVF=0.
- 65 beats of 0x7FFFFFF. Required: OUT_SUM=0x007FFFFBF, OUT_OVF=1, OUT_COUNT=65.
- Backpressure: packet {10,20(last)}, then 7(last) streamed, OUT_READY=0 for 5 cycles.
  - OUT_SUM=30 holds with OUT_VALID=1.
  - Beat 7 is captured in S1, then IN_READY=0.
  - After OUT_READY=1, second result is OUT_SUM=7, OUT_COUNT=1, OUT_OVF=0.
- RST_N=0 for one cycle after 2 beats of a 4-beat packet. Required:
  - All outputs 0, IN_READY=0 during reset.
  - A fresh packet {3,4(last)} then yields OUT_SUM=7, OUT_COUNT=2.

Source files
------------

// File: rtl/lfa_accum_stage_if.sv
// Valid/ready bundle for the LFA accumulator stage:
// operand stream in, packet result out.
interface lfa_accum_stage_if #(
  parameter int CW    = 6,
  parameter int CNT_W = 16
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [26:0]      IN_DATA;
  logic             IN_LAST;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [26+CW:0]   OUT_SUM;
  logic [CNT_W-1:0] OUT_COUNT;
  logic             OUT_OVF;

  modport master (
    output IN_VALID, IN_DATA, IN_LAST, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_SUM,
    input  OUT_COUNT, OUT_OVF
  );

  modport slave (
    input  IN_VALID, IN_DATA, IN_LAST, OUT_READY,
    output IN_READY, OUT_VALID, OUT_SUM,
    output OUT_COUNT, OUT_OVF
  );
endinterface

// File: rtl/lfa_accum_stage.sv
// Packet accumulator behind a 27-bit Ladner-Fischer adder;
// carry-out feeds a wrapping upper counter.
module lfa_accum_stage #(
  parameter int CW    = 6,
  parameter int CNT_W = 16
) (
  input logic               CLK,
  input logic               RST_N,
  lfa_accum_stage_if.slave  bus
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  state_e           state_q;
  logic             s1_v_q;
  logic             s1_last_q;
  logic [26:0]      s1_data_q;
  logic [26:0]      acc_lo_q;
  logic [CW-1:0]    acc_hi_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  logic [CW-1:0]    acc_hi_d;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf_d;
  logic             drain;
  logic             rdy;
  logic             load;
  logic [27:0]      sum;

  UBLFA_26_0_26_0 u_add (
    .X (acc_lo_q),
    .Y (s1_data_q),
    .S (sum)
  );

  assign drain = s1_v_q & (state_q == ACCUM);
  assign rdy   = RST_N & (!s1_v_q | drain);
  assign load  = bus.IN_VALID & rdy;

  assign acc_hi_d = acc_hi_q + CW'(sum[27]);
  assign ovf_d    = ovf_q | (sum[27] & (&acc_hi_q));
  assign cnt_d    = (&cnt_q) ? cnt_q
                  : cnt_q + 1'b1;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ACCUM;
      s1_v_q    <= 1'b0;
      s1_last_q <= 1'b0;
      s1_data_q <= '0;
      acc_lo_q  <= '0;
      acc_hi_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (load) begin
        s1_v_q    <= 1'b1;
        s1_data_q <= bus.IN_DATA;
        s1_last_q <= bus.IN_LAST;
      end else if (drain) begin
        s1_v_q    <= 1'b0;
      end
      unique case (state_q)
        ACCUM: begin
          if (drain) begin
            acc_lo_q <= sum[26:0];
            acc_hi_q <= acc_hi_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            if (s1_last_q)
              state_q <= DONE;
          end
        end
        DONE: begin
          // held S1 beat waits one edge
          if (bus.OUT_READY) begin
            acc_lo_q <= '0;
            acc_hi_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            state_q  <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign bus.IN_READY  = rdy;
  assign bus.OUT_VALID = RST_N & (state_q == DONE);
  assign bus.OUT_SUM   = RST_N ? {acc_hi_q, acc_lo_q}
                       : '0;
  assign bus.OUT_COUNT = RST_N ? cnt_q : '0;
  assign bus.OUT_OVF   = RST_N & ovf_q;

endmodule

module UBLFA_26_0_26_0 (
  input  logic [26:0] X,
  input  logic [26:0] Y,
  output logic [27:0] S
);

  logic [26:0] g;
  logic [26:0] p;

  // g[i] ends as the group generate of bits [0..i]
  always_comb begin
    g = X & Y;
    p = X ^ Y;
    for (int l = 0; l < 5; l++) begin
      for (int b = (1 << l); b < 27; b += (2 << l)) begin
        for (int k = 0; k < (1 << l); k++) begin
          if (b + k < 27) begin
            g[b+k] = g[b+k] | (p[b+k] & g[b-1]);
            p[b+k] = p[b+k] & p[b-1];
          end
        end
      end
    end
    S = {g[26], (X ^ Y) ^ {g[25:0], 1'b0}};
  end

endmodule

// File: tb/tb_lfa_accum_stage.sv
// Randomized and directed bench for lfa_accum_stage
// against a packet-level arithmetic model.
module tb_lfa_accum_stage;

  localparam int CW    = 6;
  localparam int CNT_W = 16;
  localparam int SW    = 27 + CW;
  localparam logic [63:0] MASK = (64'd1 << SW) - 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  lfa_accum_stage_if #(.CW(CW), .CNT_W(CNT_W)) bus ();

  lfa_accum_stage #(.CW(CW), .CNT_W(CNT_W)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] sum;
    int          cnt;
    bit          ovf;
  } res_t;

  res_t        exp_q[$];
  logic [63:0] acc_sum = '0;
  int          acc_n   = 0;
  int          n_vec   = 0;
  int          n_err   = 0;
  int          n_acc   = 0;
  int          exp_n   = 0;
  logic [63:0] got_sum;
  int          got_cnt;
  bit          got_ovf;
  bit          rdone;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               nm, act, exp);
    end
  endtask

  // model: whole-packet arithmetic on accepted beats
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_sum = '0;
      acc_n   = 0;
    end else begin
      if (bus.OUT_VALID) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_valid: got 1 want 0");
        end else begin
          chk("sum", bus.OUT_SUM, exp_q[0].sum);
          chk("count", bus.OUT_COUNT, exp_q[0].cnt);
          chk("ovf", bus.OUT_OVF, exp_q[0].ovf);
          if (bus.OUT_READY) begin
            void'(exp_q.pop_front());
            got_sum = bus.OUT_SUM;
            got_cnt = bus.OUT_COUNT;
            got_ovf = bus.OUT_OVF;
            n_acc++;
          end
        end
      end
      if (bus.IN_VALID && bus.IN_READY) begin
        acc_sum += bus.IN_DATA;
        acc_n++;
        if (bus.IN_LAST) begin
          exp_q.push_back('{
            acc_sum & MASK,
            (acc_n > CMAX) ? CMAX : acc_n,
            acc_sum > MASK});
          acc_sum = '0;
          acc_n   = 0;
        end
      end
    end
  end

  task automatic send(input logic [26:0] d,
                      input logic l);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    bus.IN_VALID = 1'b1;
    bus.IN_DATA  = d;
    bus.IN_LAST  = l;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.IN_READY;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got 0 want 1");
    end
    bus.IN_VALID = 1'b0;
  endtask

  task automatic expect_pkt(input string nm,
                            input logic [63:0] s,
                            input int c,
                            input bit o);
    int n;
    n = 0;
    exp_n++;
    while (n_acc < exp_n && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_arrived"}, n_acc, exp_n);
    chk({nm, "_sum"}, got_sum, s);
    chk({nm, "_cnt"}, got_cnt, c);
    chk({nm, "_ovf"}, got_ovf, o);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, bus.OUT_VALID, 0);
    chk({nm, "_sum"}, bus.OUT_SUM, 0);
    chk({nm, "_cnt"}, bus.OUT_COUNT, 0);
    chk({nm, "_ovf"}, bus.OUT_OVF, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.IN_VALID  = 1'b0;
    bus.IN_DATA   = '0;
    bus.IN_LAST   = 1'b0;
    bus.OUT_READY = 1'b0;
    rdone         = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("rst");
    chk("rst_rdy", bus.IN_READY, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_rdy", bus.IN_READY, 1);
    @(posedge clk);
    #1;

    bus.OUT_READY = 1'b1;
    send(27'h7FFFFFF, 1'b0);
    send(27'h7FFFFFF, 1'b0);
    send(27'h0000001, 1'b1);
    @(negedge clk);
    chk("lat_t0", bus.OUT_VALID, 0);
    @(negedge clk);
    chk("lat_t1", bus.OUT_VALID, 1);
    @(negedge clk);
    chk("lat_t2", bus.OUT_VALID, 0);
    @(posedge clk);
    #1;
    expect_pkt("p3", 64'h0FFFFFFF, 3, 1'b0);

    send(27'd5, 1'b1);
    expect_pkt("single", 64'd5, 1, 1'b0);

    for (int i = 0; i < 64; i++)
      send(27'h7FFFFFF, i == 63);
    expect_pkt("b64", 64'h1FFFFFFC0, 64, 1'b0);

    for (int i = 0; i < 65; i++)
      send(27'h7FFFFFF, i == 64);
    expect_pkt("b65", 64'h07FFFFBF, 65, 1'b1);

    bus.OUT_READY = 1'b0;
    send(27'd10, 1'b0);
    send(27'd20, 1'b1);
    send(27'd7, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", bus.OUT_VALID, 1);
      chk("bp_sum", bus.OUT_SUM, 30);
      chk("bp_rdy", bus.IN_READY, 0);
    end
    @(posedge clk);
    #1;
    bus.OUT_READY = 1'b1;
    expect_pkt("bp_a", 64'd30, 2, 1'b0);
    expect_pkt("bp_b", 64'd7, 1, 1'b0);

    send(27'd1, 1'b0);
    send(27'd2, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("mid_rst");
    chk("mid_rst_rdy", bus.IN_READY, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("post_rst");
    @(posedge clk);
    #1;
    send(27'd3, 1'b0);
    send(27'd4, 1'b1);
    expect_pkt("after_rst", 64'd7, 2, 1'b0);

    fork
      begin
        for (int p = 0; p < 40; p++) begin
          int len;
          len = $urandom_range(1, 8);
          for (int b = 0; b < len; b++) begin
            logic [26:0] d;
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
            d = ($urandom_range(0, 3) == 0)
              ? 27'h7FFFFFF : 27'($urandom);
            if ($urandom_range(0, 7) == 0)
              d = '0;
            send(d, b == len - 1);
          end
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1;
          bus.OUT_READY = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.OUT_READY = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rand_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
